// File: rtl/pong_frame_scheduler.sv
// Per-frame sequencer for a pong game: serve countdown, ball/paddle update handshakes,
// wall scoring, win detection and a count of frame ticks that arrive while a frame is still busy.
module pong_frame_scheduler #(
    parameter logic [3:0] WIN_SCORE    = 4'd9,
    parameter logic [7:0] SERVE_FRAMES = 8'd60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        start_game,
    input  logic [31:0] dimensions,
    input  logic [31:0] ball_pos,
    output logic        ball_upd_req,
    input  logic        ball_upd_done,
    output logic        pad_upd_req,
    output logic        pad_sel,
    input  logic        pad_upd_done,
    output logic        center_pulse,
    output logic [3:0]  score_left,
    output logic [3:0]  score_right,
    output logic        game_over,
    output logic [7:0]  overrun_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        SERVE,
        WAIT,
        BALL,
        PAD_L,
        PAD_R,
        CHECK,
        OVER
    } state_t;

    // A zero win score would make the game unwinnable, so it behaves as one point.
    localparam logic [3:0] WIN_EFF = (WIN_SCORE == 4'd0) ? 4'd1 : WIN_SCORE;

    state_t     state_reg, state_next;
    logic [7:0] serve_cnt_reg, serve_cnt_next;
    logic [3:0] score_left_reg, score_left_next;
    logic [3:0] score_right_reg, score_right_next;
    logic [7:0] overrun_reg, overrun_next;
    logic       center_reg, center_next;

    logic [15:0] ball_x;
    logic [15:0] width;
    logic [15:0] right_edge;
    logic        hit_left_wall;
    logic        hit_right_wall;
    logic        busy_state;
    logic [3:0]  left_inc;
    logic [3:0]  right_inc;
    logic        unused_y;

    assign ball_x   = ball_pos[31:16];
    assign width    = dimensions[31:16];
    assign unused_y = ^{ball_pos[15:0], dimensions[15:0]};

    // Zero width is treated as one so the edge column never underflows.
    assign right_edge     = (width == 16'd0) ? 16'd0 : width - 16'd1;
    assign hit_left_wall  = (ball_x == 16'd0);
    assign hit_right_wall = !hit_left_wall && (ball_x >= right_edge);

    assign left_inc  = (score_left_reg  < WIN_EFF) ? score_left_reg  + 4'd1 : score_left_reg;
    assign right_inc = (score_right_reg < WIN_EFF) ? score_right_reg + 4'd1 : score_right_reg;

    assign busy_state = (state_reg == BALL) || (state_reg == PAD_L) ||
                        (state_reg == PAD_R) || (state_reg == CHECK);

    always_comb begin
        state_next       = state_reg;
        serve_cnt_next   = serve_cnt_reg;
        score_left_next  = score_left_reg;
        score_right_next = score_right_reg;
        overrun_next     = overrun_reg;
        center_next      = 1'b0;

        if (frame_tick && busy_state && (overrun_reg != 8'hFF)) begin
            overrun_next = overrun_reg + 8'd1;
        end

        case (state_reg)
            IDLE, OVER: begin
                if (start_game) begin
                    score_left_next  = 4'd0;
                    score_right_next = 4'd0;
                    overrun_next     = 8'd0;
                    serve_cnt_next   = SERVE_FRAMES;
                    center_next      = 1'b1;
                    state_next       = SERVE;
                end
            end
            SERVE: begin
                if (frame_tick) begin
                    if (serve_cnt_reg == 8'd0) begin
                        state_next = BALL;
                    end else begin
                        serve_cnt_next = serve_cnt_reg - 8'd1;
                    end
                end
            end
            WAIT: begin
                if (frame_tick) begin
                    state_next = BALL;
                end
            end
            BALL: begin
                if (ball_upd_done) begin
                    state_next = PAD_L;
                end
            end
            PAD_L: begin
                if (pad_upd_done) begin
                    state_next = PAD_R;
                end
            end
            PAD_R: begin
                if (pad_upd_done) begin
                    state_next = CHECK;
                end
            end
            CHECK: begin
                if (hit_left_wall || hit_right_wall) begin
                    if (hit_left_wall) begin
                        score_right_next = right_inc;
                    end else begin
                        score_left_next = left_inc;
                    end
                    // Only the scorer's new total can reach the winning value.
                    if ((hit_left_wall ? right_inc : left_inc) == WIN_EFF) begin
                        state_next = OVER;
                    end else begin
                        serve_cnt_next = SERVE_FRAMES;
                        center_next    = 1'b1;
                        state_next     = SERVE;
                    end
                end else begin
                    state_next = WAIT;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= IDLE;
            serve_cnt_reg   <= 8'd0;
            score_left_reg  <= 4'd0;
            score_right_reg <= 4'd0;
            overrun_reg     <= 8'd0;
            center_reg      <= 1'b0;
        end else begin
            state_reg       <= state_next;
            serve_cnt_reg   <= serve_cnt_next;
            score_left_reg  <= score_left_next;
            score_right_reg <= score_right_next;
            overrun_reg     <= overrun_next;
            center_reg      <= center_next;
        end
    end

    // Requests are pure state decodes, so they vanish the moment reset forces IDLE.
    assign ball_upd_req = (state_reg == BALL);
    assign pad_upd_req  = (state_reg == PAD_L) || (state_reg == PAD_R);
    assign pad_sel      = (state_reg == PAD_R);
    assign game_over    = (state_reg == OVER);
    assign center_pulse = center_reg;
    assign score_left   = score_left_reg;
    assign score_right  = score_right_reg;
    assign overrun_cnt  = overrun_reg;

endmodule
